mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access and write-back stage of the 16-bit pipeline, between the EX/MEM pipeline register and the register file.
- Performs load/store handshakes with a variable-latency data memory and stalls upstream while an access is pending.
- Emits exactly one write-back command (wb_addr, wb_data, reg_op) per retired instruction to the register file.
- Mirrors that command on forwarding outputs for the decode stage.

Parameters:
- TIMEOUT_CYCLES, 15: ACCESS cycles waited for mem_ready before the access is aborted.
- TO_CNT_W, 4: width of the timeout counter; must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_50MHz  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction valid this cycle.
- in_reg_op  in  3  write-back target class (REG_OP_NOP/REG/T/SP/IH/RA).
- in_wb_addr  in  3  general register index; used only when the op is REG_OP_REG.
- in_alu_data  in  16  EX result; also the memory address for loads and stores.
- in_mem_rd  in  1  instruction is a load.
- in_mem_wr  in  1  instruction is a store.
- in_store_data  in  16  store data.
- flush  in  1  kill the instruction offered this cycle.
- mem_req  out  1  memory request, held until mem_ready or timeout.
- mem_we  out  1  request is a write.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  store data.
- mem_rdata  in  16  load data, valid when mem_ready=1.
- mem_ready  in  1  access complete.
- stall_req  out  1  upstream must hold its outputs this cycle.
- wb_addr  out  3  register-file write index.
- wb_data  out  16  register-file write data.
- reg_op  out  3  register-file write command.
- fwd_op  out  3  forwarding copy of reg_op.
- fwd_addr  out  3  forwarding copy of wb_addr.
- fwd_data  out  16  forwarding copy of wb_data.
- mem_err  out  1  one-cycle pulse on access timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - reg_op=REG_OP_NOP, wb_addr=0, wb_data=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_err=0.
  - A reset during ACCESS abandons the access with no write-back.
- Registered outputs: wb_*, reg_op and mem_* are registered. Forwarding outputs equal the registered wb_* and reg_op combinationally.
- Default: reg_op returns to REG_OP_NOP on every edge that commits nothing, so each command is high for exactly one cycle.
- State IDLE:
  - Offered instruction = in_valid & ~flush. If it is not offered, commit nothing.
  - Offered with in_mem_rd=0 and in_mem_wr=0: on the next edge wb_addr=in_wb_addr, wb_data=in_alu_data, reg_op=in_reg_op. Latency is 1 cycle; stall_req=0.
  - Offered with in_mem_rd or in_mem_wr:
    - stall_req=1 combinationally in the same cycle.
    - On the edge: latch in_reg_op and in_wb_addr; mem_req=1; mem_we=in_mem_wr; mem_addr=in_alu_data; mem_wdata=in_store_data; counter=0; go to ACCESS.
    - If both rd and wr are set, the access is treated as a store.
- State ACCESS:
  - stall_req = ~mem_ready; flush is ignored.
  - mem_ready=1 (including on the first ACCESS cycle):
    - Load: next edge wb_data=mem_rdata, wb_addr and reg_op from the latched values.
    - Store: reg_op=REG_OP_NOP.
    - In both cases mem_req=0, go to IDLE. The upstream instruction is accepted in IDLE on the following cycle.
  - mem_ready=0 with counter == TIMEOUT_CYCLES-1:
    - Next edge: mem_req=0, mem_err=1 for one cycle, reg_op=REG_OP_NOP, go to IDLE.
    - stall_req drops to 0 in the cycle after the abort.
  - Otherwise: counter increments and mem_req stays asserted.
- A NOP-class instruction (in_reg_op=NOP) still occupies its slot, with no write.

Decomposition:
- Add to define.v:
  - REG_OP_* encodings, REG_OP_BUS, DATA_BUS, REG_ADDR_BUS.
  - New state encodings MWB_IDLE and MWB_ACCESS.
- Sub-module mem_timeout_counter: TO_CNT_W-bit counter with clear/enable and an expire flag. It is natural to split out; everything else stays flat.

Test Plan:
- ALU passthrough: in_valid=1, op=REG, addr=3, alu=0x1234 -> next cycle reg_op=REG, wb_addr=3, wb_data=0x1234, stall_req=0. The following cycle reg_op=NOP.
- Load with latency 3: rd=1, alu=0x8000, op=REG, addr=5; mem_ready rises on the 3rd ACCESS cycle with rdata=0xBEEF.
  - mem_req=1 and mem_addr=0x8000 for 3 cycles.
  - stall_req high 3 cycles, then a one-cycle write of addr 5 = 0xBEEF.
- Store, zero wait: wr=1, alu=0x0010, store_data=0x00AA, mem_ready=1 immediately -> mem_we=1, mem_wdata=0x00AA for one cycle; no reg_op pulse.
- Timeout: load with mem_ready held 0 -> mem_req high exactly 15 cycles, then mem_err pulses once, reg_op stays NOP, state returns to IDLE.
- Flush and reset:
  - flush=1 with a valid SP write -> no commit.
  - rst asserted mid-ACCESS -> all outputs zero/NOP immediately; no write after rst is released.
- Back-to-back: ALU op to T, then a load to RA, then an ALU op to IH -> commits in order: T, RA (after memory), IH. fwd_* match wb_* every cycle.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared types and encodings for the MEM/WB stage: register-file write
// command classes, bus widths and the stage state machine encoding.
package mem_wb_stage_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int REG_OP_W   = 3;

    typedef logic [DATA_W-1:0]     data_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;
    typedef logic [REG_OP_W-1:0]   reg_op_bus_t;

    localparam reg_op_bus_t REG_OP_NOP = 3'd0;
    localparam reg_op_bus_t REG_OP_REG = 3'd1;
    localparam reg_op_bus_t REG_OP_T   = 3'd2;
    localparam reg_op_bus_t REG_OP_SP  = 3'd3;
    localparam reg_op_bus_t REG_OP_IH  = 3'd4;
    localparam reg_op_bus_t REG_OP_RA  = 3'd5;

    typedef enum logic {
        MWB_IDLE   = 1'b0,
        MWB_ACCESS = 1'b1
    } mwb_state_t;

    // A load/store flag pair with both bits set is treated as a store.
    function automatic logic is_mem_access(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mem_wb_stage_mem_timeout_counter.sv
// Counts ACCESS cycles spent waiting on the data memory and flags the
// cycle on which the wait budget is used up.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_CNT_W       = 4
) (
    input  logic clk_50MHz,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TO_CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == TO_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: runs load/store handshakes against a variable-latency
// data memory and issues one write-back command per retired instruction.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_CNT_W       = 4
) (
    input  logic                  clk_50MHz,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [REG_OP_W-1:0]   in_reg_op,
    input  logic [REG_ADDR_W-1:0] in_wb_addr,
    input  logic [DATA_W-1:0]     in_alu_data,
    input  logic                  in_mem_rd,
    input  logic                  in_mem_wr,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall_req,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic [REG_OP_W-1:0]   reg_op,
    output logic [REG_OP_W-1:0]   fwd_op,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  mem_err
);

    mwb_state_t    state;
    reg_op_bus_t   op_q;
    reg_addr_bus_t addr_q;
    logic          offered;
    logic          mem_op;
    logic          expire;

    assign offered = in_valid & ~flush;
    assign mem_op  = is_mem_access(in_mem_rd, in_mem_wr);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_CNT_W       (TO_CNT_W)
    ) u_timeout (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .clear     (state == MWB_IDLE),
        .enable    ((state == MWB_ACCESS) && !mem_ready),
        .expire    (expire)
    );

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        stall_req = 1'b0;
        unique case (state)
            MWB_IDLE:   stall_req = offered & mem_op;
            MWB_ACCESS: stall_req = ~mem_ready;
            default:    stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state     <= MWB_IDLE;
            op_q      <= REG_OP_NOP;
            addr_q    <= '0;
            reg_op    <= REG_OP_NOP;
            wb_addr   <= '0;
            wb_data   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            // Commands and the error flag are single-cycle pulses by default.
            reg_op  <= REG_OP_NOP;
            mem_err <= 1'b0;
            unique case (state)
                MWB_IDLE: begin
                    if (offered && mem_op) begin
                        op_q      <= in_reg_op;
                        addr_q    <= in_wb_addr;
                        mem_req   <= 1'b1;
                        mem_we    <= in_mem_wr;
                        mem_addr  <= in_alu_data;
                        mem_wdata <= in_store_data;
                        state     <= MWB_ACCESS;
                    end else if (offered) begin
                        wb_addr <= in_wb_addr;
                        wb_data <= in_alu_data;
                        reg_op  <= in_reg_op;
                    end
                end
                MWB_ACCESS: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            wb_addr <= addr_q;
                            wb_data <= mem_rdata;
                            reg_op  <= op_q;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= MWB_IDLE;
                    end else if (expire) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= MWB_IDLE;
                    end
                end
                default: state <= MWB_IDLE;
            endcase
        end
    end

    assign fwd_op   = reg_op;
    assign fwd_addr = wb_addr;
    assign fwd_data = wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases followed by a random
// instruction stream, checked against a transaction-level timing model.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk_50MHz = 1'b0;
    logic        rst;
    logic        in_valid, in_mem_rd, in_mem_wr, flush, mem_ready;
    logic [2:0]  in_reg_op, in_wb_addr;
    logic [15:0] in_alu_data, in_store_data, mem_rdata;
    logic        mem_req, mem_we, stall_req, mem_err;
    logic [15:0] mem_addr, mem_wdata, wb_data, fwd_data;
    logic [2:0]  wb_addr, reg_op, fwd_op, fwd_addr;

    int total = 0;
    int bad   = 0;

    // Model of the register-file port: last written address/data.
    logic [2:0]  m_addr;
    logic [15:0] m_data;

    mem_wb_stage #(.TIMEOUT_CYCLES(TIMEOUT), .TO_CNT_W(4)) dut (
        .clk_50MHz     (clk_50MHz),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_reg_op     (in_reg_op),
        .in_wb_addr    (in_wb_addr),
        .in_alu_data   (in_alu_data),
        .in_mem_rd     (in_mem_rd),
        .in_mem_wr     (in_mem_wr),
        .in_store_data (in_store_data),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .stall_req     (stall_req),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .reg_op        (reg_op),
        .fwd_op        (fwd_op),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
        .mem_err       (mem_err)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register-file port and its forwarding copy against the model.
    task automatic check_wb(input string tag, input logic [2:0] exp_op);
        check({tag, ".reg_op"},   reg_op,   exp_op);
        check({tag, ".wb_addr"},  wb_addr,  m_addr);
        check({tag, ".wb_data"},  wb_data,  m_data);
        check({tag, ".fwd_op"},   fwd_op,   exp_op);
        check({tag, ".fwd_addr"}, fwd_addr, m_addr);
        check({tag, ".fwd_data"}, fwd_data, m_data);
    endtask

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    // One ALU-class slot: commits one cycle later unless invalid or flushed.
    task automatic do_alu(input string tag, input logic valid, input logic fl,
                          input logic [2:0] op, input logic [2:0] addr, input logic [15:0] data);
        logic commit;
        commit        = valid & ~fl;
        in_valid      = valid;
        flush         = fl;
        in_mem_rd     = 1'b0;
        in_mem_wr     = 1'b0;
        in_reg_op     = op;
        in_wb_addr    = addr;
        in_alu_data   = data;
        in_store_data = 16'($urandom);
        #1;
        check({tag, ".stall"}, stall_req, 1'b0);
        tick();
        if (commit) begin
            m_addr = addr;
            m_data = data;
        end
        check_wb(tag, commit ? op : REG_OP_NOP);
        check({tag, ".mem_req"}, mem_req, 1'b0);
        check({tag, ".mem_err"}, mem_err, 1'b0);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // One load/store: memory answers on ACCESS cycle `lat` (1-based); a
    // latency beyond the timeout budget never answers and must abort.
    task automatic do_mem(input string tag, input logic rd, input logic wr,
                          input logic [2:0] op, input logic [2:0] addr,
                          input logic [15:0] alu, input logic [15:0] sdata,
                          input int lat, input logic [15:0] rdata);
        int   n;
        logic done, is_store;
        is_store      = wr;
        done          = (lat <= TIMEOUT);
        n             = done ? lat : TIMEOUT;
        in_valid      = 1'b1;
        flush         = 1'b0;
        in_mem_rd     = rd;
        in_mem_wr     = wr;
        in_reg_op     = op;
        in_wb_addr    = addr;
        in_alu_data   = alu;
        in_store_data = sdata;
        mem_ready     = 1'b0;
        #1;
        check({tag, ".stall_offer"}, stall_req, 1'b1);
        tick();
        for (int k = 1; k <= n; k++) begin
            check({tag, ".req"},  mem_req,  1'b1);
            check({tag, ".we"},   mem_we,   is_store);
            check({tag, ".addr"}, mem_addr, alu);
            if (is_store) check({tag, ".wdata"}, mem_wdata, sdata);
            check({tag, ".err_wait"}, mem_err, 1'b0);
            check_wb({tag, ".wait"}, REG_OP_NOP);
            // Upstream noise while stalled must be ignored, flush included.
            in_valid    = 1'($urandom);
            flush       = 1'($urandom);
            in_mem_rd   = 1'($urandom);
            in_mem_wr   = 1'($urandom);
            in_reg_op   = 3'($urandom_range(0, 5));
            in_wb_addr  = 3'($urandom);
            in_alu_data = 16'($urandom);
            mem_ready   = (k == lat);
            mem_rdata   = (k == lat) ? rdata : 16'($urandom);
            #1;
            check({tag, ".stall_wait"}, stall_req, !(k == lat));
            tick();
        end
        if (done && !is_store) begin
            m_addr = addr;
            m_data = rdata;
        end
        check({tag, ".req_end"}, mem_req, 1'b0);
        check({tag, ".we_end"},  mem_we,  1'b0);
        check({tag, ".err_end"}, mem_err, !done);
        check_wb({tag, ".end"}, (done && !is_store) ? op : REG_OP_NOP);
        mem_ready = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic reset_mid_access();
        m_addr = 3'd0;
        in_valid    = 1'b1;
        flush       = 1'b0;
        in_mem_rd   = 1'b1;
        in_mem_wr   = 1'b0;
        in_reg_op   = REG_OP_REG;
        in_wb_addr  = 3'd6;
        in_alu_data = 16'h4242;
        mem_ready   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check("rst_mid.req_before", mem_req, 1'b1);
        #8;
        rst = 1'b0;
        #1;
        m_addr = 3'd0;
        m_data = 16'h0;
        check_wb("rst_mid.now", REG_OP_NOP);
        check("rst_mid.req",   mem_req,   1'b0);
        check("rst_mid.we",    mem_we,    1'b0);
        check("rst_mid.addr",  mem_addr,  16'h0);
        check("rst_mid.wdata", mem_wdata, 16'h0);
        check("rst_mid.err",   mem_err,   1'b0);
        check("rst_mid.stall", stall_req, 1'b0);
        tick();
        #5;
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_wb("rst_mid.after", REG_OP_NOP);
            check("rst_mid.req_after", mem_req, 1'b0);
        end
        mem_ready = 1'b0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        {in_valid, in_mem_rd, in_mem_wr, flush, mem_ready} = '0;
        in_reg_op = '0; in_wb_addr = '0; in_alu_data = '0;
        in_store_data = '0; mem_rdata = '0;
        m_addr = '0; m_data = '0;
        #25;
        check_wb("reset", REG_OP_NOP);
        check("reset.req",   mem_req,   1'b0);
        check("reset.we",    mem_we,    1'b0);
        check("reset.addr",  mem_addr,  16'h0);
        check("reset.wdata", mem_wdata, 16'h0);
        check("reset.err",   mem_err,   1'b0);
        check("reset.stall", stall_req, 1'b0);
        #3;
        rst = 1'b1;
        tick();

        do_alu("alu_pass", 1'b1, 1'b0, REG_OP_REG, 3'd3, 16'h1234);
        do_alu("alu_idle", 1'b0, 1'b0, REG_OP_REG, 3'd1, 16'hFFFF);
        do_mem("load3", 1'b1, 1'b0, REG_OP_REG, 3'd5, 16'h8000, 16'h0, 3, 16'hBEEF);
        do_mem("store0", 1'b0, 1'b1, REG_OP_NOP, 3'd0, 16'h0010, 16'h00AA, 1, 16'h5555);
        do_alu("after_store", 1'b0, 1'b0, REG_OP_NOP, 3'd0, 16'h0);
        do_mem("timeout", 1'b1, 1'b0, REG_OP_REG, 3'd2, 16'h9000, 16'h0, 99, 16'h0);
        do_alu("after_to", 1'b0, 1'b0, REG_OP_NOP, 3'd0, 16'h0);
        do_alu("flush_sp", 1'b1, 1'b1, REG_OP_SP, 3'd0, 16'h7777);
        do_mem("rdwr_store", 1'b1, 1'b1, REG_OP_REG, 3'd4, 16'h0020, 16'h1357, 2, 16'h2468);
        do_alu("nop_slot", 1'b1, 1'b0, REG_OP_NOP, 3'd7, 16'h0BAD);
        do_alu("b2b_t", 1'b1, 1'b0, REG_OP_T, 3'd0, 16'h0001);
        do_mem("b2b_ra", 1'b1, 1'b0, REG_OP_RA, 3'd0, 16'h0100, 16'h0, 2, 16'hCAFE);
        do_alu("b2b_ih", 1'b1, 1'b0, REG_OP_IH, 3'd0, 16'h0002);
        reset_mid_access();

        for (int i = 0; i < 80; i++) begin
            int          kind;
            logic [2:0]  op, addr;
            logic [15:0] alu, sd, rd;
            int          lat;
            kind = $urandom_range(0, 4);
            op   = 3'($urandom_range(0, 5));
            addr = 3'($urandom);
            alu  = 16'($urandom);
            sd   = 16'($urandom);
            rd   = 16'($urandom);
            lat  = $urandom_range(1, 18);
            case (kind)
                0, 1:    do_alu("rnd_alu", 1'($urandom_range(0, 5) != 0),
                                1'($urandom_range(0, 4) == 0), op, addr, alu);
                2:       do_mem("rnd_load", 1'b1, 1'b0, op, addr, alu, sd, lat, rd);
                3:       do_mem("rnd_store", 1'b0, 1'b1, op, addr, alu, sd, lat, rd);
                default: do_mem("rnd_rdwr", 1'b1, 1'b1, op, addr, alu, sd, lat, rd);
            endcase
        end
        do_alu("final", 1'b0, 1'b0, REG_OP_NOP, 3'd0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
